// File: rtl/pipe_pkg.sv
// Shared types for the pipeline stage register: occupancy state and level width.
package pipe_pkg;

    localparam int PIPE_LEVEL_W = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_t;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: valid flag, control bundle and LANES data words.
// Clear takes priority over load; clear leaves the data words stale.
module pipe_slot #(
    parameter int CTRL_W = 4,
    parameter int DATA_W = 64,
    parameter int LANES  = 3
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    i_load,
    input  logic                    i_clear,
    input  logic [CTRL_W-1:0]       i_ctrl,
    input  logic [LANES*DATA_W-1:0] i_data,
    output logic                    o_valid,
    output logic [CTRL_W-1:0]       o_ctrl,
    output logic [LANES*DATA_W-1:0] o_data
);

    logic                    r_valid;
    logic [CTRL_W-1:0]       r_ctrl;
    logic [LANES*DATA_W-1:0] r_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_ctrl  <= i_ctrl;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_data <= '0;
        else if (i_load && !i_clear)
            r_data <= i_data;
    end

    assign o_valid = r_valid;
    assign o_ctrl  = r_ctrl;
    assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// Reusable inter-stage register with valid/ready handshake, flush and optional
// skid entry. With SKID=1 in_ready comes from a flop and out_* from the main slot only.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = 4,
    parameter int DATA_W = 64,
    parameter int LANES  = 3,
    parameter int SKID   = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CTRL_W-1:0]       in_ctrl,
    input  logic [LANES*DATA_W-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CTRL_W-1:0]       out_ctrl,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic [PIPE_LEVEL_W-1:0] level
);

    pipe_state_t r_state, w_state_nxt;
    logic        r_in_rdy;
    logic        w_in_fire, w_out_fire;

    logic                    w_main_load, w_main_clr, w_main_from_skid;
    logic                    w_skid_load, w_skid_clr;
    logic                    w_main_vld, w_skid_vld;
    logic [CTRL_W-1:0]       w_main_ctrl, w_skid_ctrl, w_main_cin;
    logic [LANES*DATA_W-1:0] w_main_data, w_skid_data, w_main_din;

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = w_main_vld & out_ready;

    // State register, plus the ready flop that looks one state ahead.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= EMPTY;
            r_in_rdy <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_in_rdy <= (SKID != 0) ? (w_state_nxt != TWO) : 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = EMPTY;
        end else begin
            case (r_state)
                EMPTY: if (w_in_fire) w_state_nxt = ONE;
                ONE: begin
                    if (w_in_fire && !w_out_fire)
                        w_state_nxt = (SKID != 0) ? TWO : ONE;
                    else if (!w_in_fire && w_out_fire)
                        w_state_nxt = EMPTY;
                end
                TWO:     if (w_out_fire) w_state_nxt = ONE;
                default: w_state_nxt = EMPTY;
            endcase
        end
    end

    always_comb begin
        w_main_load      = 1'b0;
        w_main_clr       = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_load      = 1'b0;
        w_skid_clr       = 1'b0;
        if (flush) begin
            w_main_clr = 1'b1;
            w_skid_clr = 1'b1;
        end else begin
            case (r_state)
                EMPTY: w_main_load = w_in_fire;
                ONE: begin
                    if (w_in_fire && w_out_fire)
                        w_main_load = 1'b1;
                    else if (w_in_fire)
                        w_skid_load = 1'b1;
                    else if (w_out_fire)
                        w_main_clr = 1'b1;
                end
                TWO: begin
                    if (w_out_fire) begin
                        w_main_load      = 1'b1;
                        w_main_from_skid = 1'b1;
                        w_skid_clr       = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_main_cin = w_main_from_skid ? w_skid_ctrl : in_ctrl;
    assign w_main_din = w_main_from_skid ? w_skid_data : in_data;

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .LANES(LANES)) u_main (
        .clk     (clk),
        .reset_n (reset_n),
        .i_load  (w_main_load),
        .i_clear (w_main_clr),
        .i_ctrl  (w_main_cin),
        .i_data  (w_main_din),
        .o_valid (w_main_vld),
        .o_ctrl  (w_main_ctrl),
        .o_data  (w_main_data)
    );

    generate
        if (SKID != 0) begin : g_skid
            pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .LANES(LANES)) u_skid (
                .clk     (clk),
                .reset_n (reset_n),
                .i_load  (w_skid_load),
                .i_clear (w_skid_clr),
                .i_ctrl  (in_ctrl),
                .i_data  (in_data),
                .o_valid (w_skid_vld),
                .o_ctrl  (w_skid_ctrl),
                .o_data  (w_skid_data)
            );
            assign in_ready = r_in_rdy & ~flush;
        end else begin : g_noskid
            logic w_skid_unused;
            assign w_skid_unused = w_skid_load | w_skid_clr;
            assign w_skid_vld    = 1'b0;
            assign w_skid_ctrl   = '0;
            assign w_skid_data   = '0;
            // r_in_rdy only masks the cycle(s) before the first edge out of reset.
            assign in_ready = r_in_rdy & (~w_main_vld | out_ready) & ~flush;
        end
    endgenerate

    assign out_valid = w_main_vld;
    assign out_ctrl  = w_main_ctrl & {CTRL_W{w_main_vld}};
    assign out_data  = w_main_data;
    assign level     = {1'b0, w_main_vld} + {1'b0, w_skid_vld};

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register that generalises the fixed inter-stage latches (EX/MEM style) into one reusable block. It carries a bundle of control bits and `LANES` data words between two pipeline stages with a valid/ready handshake, stall via back-pressure, synchronous flush (bubble insertion), and an optional skid entry so `in_ready` is fully registered. Every stage boundary in the CPU pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB) instantiates it.

## Interface
- `CTRL_W`, 4: width of control bundle (write enables, mux selects); zeroed on bubble/flush.
- `DATA_W`, 64: width of one data lane.
- `LANES`, 3: number of data lanes (e.g. ALU result, store data, shift result).
- `SKID`, 1: 1 = two-entry skid mode, registered `in_ready`; 0 = single entry, combinational `in_ready`.
- `clk`  in  1  clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous; discard all held entries this edge.
- `in_valid`  in  1  upstream entry valid.
- `in_ready`  out  1  stage can accept this cycle.
- `in_ctrl`  in  CTRL_W  upstream control bundle.
- `in_data`  in  LANES*DATA_W  upstream lanes, lane 0 in LSBs.
- `out_valid`  out  1  downstream entry valid.
- `out_ready`  in  1  downstream accepts this cycle.
- `out_ctrl`  out  CTRL_W  held control; forced 0 whenever `out_valid`=0.
- `out_data`  out  LANES*DATA_W  held lanes.
- `level`  out  2  entries held (0..2; max 1 when `SKID`=0).

## Operation
- Transfer in: `in_valid && in_ready` at rising edge. Transfer out: `out_valid && out_ready`.
- Order preserved; no entry duplicated or dropped except by `flush`.
- State (SKID=1): EMPTY (level 0), ONE (main slot full), TWO (main+skid full).
  - EMPTY: in -> ONE.
  - ONE: in only -> TWO (entry to skid); out only -> EMPTY; in+out -> ONE (main reloads).
  - TWO: out -> ONE (skid moves to main); no input accepted.
- `in_ready` (SKID=1) = registered `state != TWO`, gated by `~flush`.
- SKID=0: single slot; `in_ready = (~out_valid | out_ready) & ~flush`; states EMPTY/ONE only.
- `flush`: next state EMPTY, all valids 0, ctrl cleared; data regs hold stale values (don't-care). Flush overrides simultaneous in/out transfers; no input accepted that cycle. Downstream may still sample `out_valid`/`out_ctrl` that cycle, but upstream treats the entry as discarded.
- Bubble rule: `out_ctrl` is `ctrl & {CTRL_W{out_valid}}`, so a bubble never asserts a write enable.

## Timing
- Latency in->out: 1 cycle in EMPTY; in ONE with `out_ready`=0, entry waits in skid.
- Throughput: 1 entry/cycle sustained while `out_ready`=1, both modes.
- SKID=1: no combinational path from `out_ready` to `in_ready`; `out_*` driven from main slot flops only.
- Reset (asynchronous assert, `reset_n`=0): `out_valid`=0, `out_ctrl`=0, `out_data`=0, `level`=0, `in_ready`=0, state EMPTY. First edge after deassert: `in_ready`=1.
- Reset mid-operation: held entries lost immediately, no partial transfer.
- `flush` and `reset_n` both: reset dominates.

## Structure
- Package `pipe_pkg`: `pipe_state_t` enum (EMPTY, ONE, TWO), level width constant `PIPE_LEVEL_W`=2.
- Sub-module `pipe_slot`: one entry (valid + ctrl + LANES*DATA_W data) with load, clear, async active-low reset; instantiated once (SKID=0) or twice (SKID=1).
- Top holds FSM, ready generation, skid/main muxing, ctrl gating.

## Test plan
- Reset: hold `reset_n`=0 with `in_valid`=1 -> `out_valid`=0, `out_ctrl`=0, `in_ready`=0; release -> `in_ready`=1 next edge.
- Streaming (SKID=1, `out_ready`=1): push entries ctrl=4'hA..4'hD, lane0=1..4 back-to-back -> identical sequence out, 1-cycle latency, `level` stays 1.
- Back-pressure: `out_ready`=0, push 3 entries -> first two accepted, `level`=2, `in_ready`=0; raise `out_ready` -> 2 entries out in order, then third.
- Flush with full stage: `level`=2, assert `flush` with `in_valid`=1 -> next cycle `level`=0, `out_valid`=0, `out_ctrl`=0, pending input not accepted.
- SKID=0 simultaneous in/out: held entry X, `out_ready`=1, `in_valid`=1 with Y -> `in_ready`=1, X transfers, Y held next cycle.
- Async reset mid-stream: drop `reset_n` between edges with `level`=2 -> outputs clear immediately, no entry emitted after release.
